irrigation_scheduler: RTL and testbench
=======================================

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter ASP_TIME, default 10, sprinkler run length in tick pulses; legal range 1..255.
REQ-002 Parameter GOT_TIME, default 20, drip run length in tick pulses; legal range 1..255.
REQ-003 Parameter PAUSE_TIME, default 2, pump settle interval in tick pulses between runs; legal range 1..255.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  single-cycle time-base enable pulse; timers advance only on cycles with tick=1.
REQ-007 req_asp  input  1  sprinkler zone requests water; level-sensitive.
REQ-008 req_got  input  1  drip zone requests water; level-sensitive.
REQ-009 tank_low  input  1  water tank below minimum level; level-sensitive.
REQ-010 clr_fault  input  1  operator fault acknowledge; used only per REQ-030.
REQ-011 rega  output  2  mode command {asp,got}: 00 none, 10 sprinkler, 01 drip; 11 never driven.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 alarm  output  1  high whenever state is FAULT.

Function
REQ-014 The FSM SHALL have states IDLE, RUN_ASP, RUN_GOT, PAUSE, FAULT; all outputs are registered decodes of state.
REQ-015 rega SHALL be 10 in RUN_ASP, 01 in RUN_GOT, 00 in all other states.
REQ-016 IDLE: exactly one request high -> RUN of that zone on the next edge; no request -> stay in IDLE.
REQ-017 IDLE with both requests high SHALL grant the zone not served last (round-robin via a last_served flag, updated on RUN entry).
REQ-018 RUN entry SHALL load the 8-bit run timer with ASP_TIME or GOT_TIME.
REQ-019 Each tick in RUN SHALL decrement the timer; the tick that takes it from 1 to 0 SHALL cause PAUSE on the next edge, so rega is high for exactly N tick pulses plus the sub-tick phase.
REQ-020 Deassertion of the running zone's request in RUN SHALL cause PAUSE on the next edge (early stop).
REQ-021 PAUSE entry SHALL load PAUSE_TIME; the expiring tick SHALL cause IDLE on the next edge; requests are ignored during PAUSE.
REQ-022 Direct RUN_ASP<->RUN_GOT transitions SHALL NOT exist; every mode change passes through PAUSE.
REQ-023 tank_low=1 in IDLE, RUN_* or PAUSE SHALL force FAULT on the next edge, overriding all other transitions.
REQ-024 tick arriving in the same cycle as tank_low SHALL be ignored; FAULT wins.
REQ-025 FAULT exit SHALL always go to PAUSE (loading PAUSE_TIME), never directly to RUN.
REQ-026 The timer SHALL hold its value in IDLE and FAULT; it never underflows below 0.

Reset
REQ-027 reset=1 at a rising edge SHALL force state IDLE, timer 0, last_served=GOT (sprinkler wins first contention), rega=00, busy=0, alarm=0; this overrides tank_low and any mid-run or mid-fault state.
REQ-028 The first edge after reset deasserts SHALL evaluate REQ-016/017/023 normally.

Configuration
REQ-029 Macro IRRIG_FAULT_LATCH_EN undefined: FAULT SHALL exit to PAUSE on the first edge with tank_low=0; clr_fault is ignored.
REQ-030 Macro IRRIG_FAULT_LATCH_EN defined: FAULT SHALL be sticky and exit to PAUSE only on an edge with tank_low=0 and clr_fault=1; clr_fault while tank_low=1 has no effect.

Structure
REQ-031 Package irrig_pkg SHALL hold the state enum, the rega codes (NADA=00, ASP=10, GOT=01) and the 8-bit timer width constant.
REQ-032 The load/decrement timer SHALL be a sub-module irrig_tick_timer (inputs load, load_val, tick; output expired), instantiated once and shared by RUN and PAUSE.

Verification
REQ-033 req_asp=1 for the whole run, ASP_TIME=3, tick every 4 cycles -> rega=10 starting 1 cycle after request, PAUSE after the 3rd tick, rega=00, IDLE after 2 more ticks.
REQ-034 req_asp=req_got=1 held after reset -> grants in order ASP, GOT, ASP, each separated by a PAUSE with rega=00.
REQ-035 tank_low pulses high mid RUN_GOT -> next edge rega=00, alarm=1; macro off: tank_low=0 -> PAUSE next edge; macro on: stays FAULT until clr_fault=1.
REQ-036 req_got dropped after 5 of 20 ticks -> PAUSE next edge, full PAUSE_TIME pause, then IDLE.
REQ-037 reset asserted during RUN_ASP with tank_low=1 -> next edge IDLE, rega=00, alarm=0, busy=0; next contention grants ASP.
REQ-038 Every cycle (assertion): rega!=11, busy==(state!=IDLE), and no RUN_ASP<->RUN_GOT transition without PAUSE.

Source files
------------

// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation scheduler: FSM state encoding,
// valve mode codes and the run/pause timer width.
package irrig_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN_ASP,
        RUN_GOT,
        PAUSE,
        FAULT
    } state_e;

    localparam logic [1:0] NADA = 2'b00;
    localparam logic [1:0] ASP  = 2'b10;
    localparam logic [1:0] GOT  = 2'b01;

    function automatic logic [1:0] rega_of(input state_e s);
        case (s)
            RUN_ASP: rega_of = ASP;
            RUN_GOT: rega_of = GOT;
            default: rega_of = NADA;
        endcase
    endfunction

endpackage

// File: rtl/irrig_tick_timer.sv
// Loadable down-counter advanced by tick pulses; expired flags the tick that
// takes the count from 1 to 0. Shared by the run and pause phases.
module irrig_tick_timer
    import irrig_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // Load wins over a coincident tick; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = tick && (count == TIMER_W'(1));

endmodule

// File: rtl/irrigation_scheduler.sv
// Two-zone irrigation scheduler (sprinkler / drip) with round-robin arbitration,
// pump settle pause and tank-low fault. Define IRRIG_FAULT_LATCH_EN to make FAULT sticky until clr_fault.
module irrigation_scheduler
    import irrig_pkg::*;
#(
    parameter int ASP_TIME   = 10,
    parameter int GOT_TIME   = 20,
    parameter int PAUSE_TIME = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_asp,
    input  logic       req_got,
    input  logic       tank_low,
    input  logic       clr_fault,
    output logic [1:0] rega,
    output logic       busy,
    output logic       alarm
);

    state_e             state;
    state_e             state_next;
    logic               last_got;
    logic               load;
    logic [TIMER_W-1:0] load_val;
    logic               timer_tick;
    logic               expired;
    logic               fault_exit;

`ifdef IRRIG_FAULT_LATCH_EN
    assign fault_exit = !tank_low && clr_fault;
`else
    logic unused_clr_fault;
    assign unused_clr_fault = clr_fault;
    assign fault_exit       = !tank_low;
`endif

    // A tick coinciding with tank_low is swallowed so the timer freezes on fault entry.
    assign timer_tick = tick && !tank_low &&
                        ((state == RUN_ASP) || (state == RUN_GOT) || (state == PAUSE));

    irrig_tick_timer u_timer (
        .clk      (CLK),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (timer_tick),
        .expired  (expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_asp && (!req_got || last_got)) state_next = RUN_ASP;
                else if (req_got)                      state_next = RUN_GOT;
            end
            RUN_ASP: if (!req_asp || expired) state_next = PAUSE;
            RUN_GOT: if (!req_got || expired) state_next = PAUSE;
            PAUSE:   if (expired)             state_next = IDLE;
            FAULT:   if (fault_exit)          state_next = PAUSE;
            default:                          state_next = IDLE;
        endcase
        if (tank_low && (state != FAULT)) state_next = FAULT;
    end

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (state_next != state) begin
            case (state_next)
                RUN_ASP: begin load = 1'b1; load_val = TIMER_W'(ASP_TIME);   end
                RUN_GOT: begin load = 1'b1; load_val = TIMER_W'(GOT_TIME);   end
                PAUSE:   begin load = 1'b1; load_val = TIMER_W'(PAUSE_TIME); end
                default: begin load = 1'b0; load_val = '0;                   end
            endcase
        end
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            last_got <= 1'b1;
            rega     <= NADA;
            busy     <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == RUN_ASP) last_got <= 1'b0;
            if (state == IDLE && state_next == RUN_GOT) last_got <= 1'b1;
            rega  <= rega_of(state_next);
            busy  <= (state_next != IDLE);
            alarm <= (state_next == FAULT);
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler (ASP_TIME=3, GOT_TIME=20, PAUSE_TIME=2);
// honours IRRIG_FAULT_LATCH_EN for the fault-exit steps.
module tb_irrigation_scheduler;

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_ASP  = 2'b10;
    localparam logic [1:0] R_GOT  = 2'b01;

    logic       CLK = 1'b0;
    logic       reset;
    logic       tick;
    logic       req_asp;
    logic       req_got;
    logic       tank_low;
    logic       clr_fault;
    logic [1:0] rega;
    logic       busy;
    logic       alarm;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [1:0] prev_rega = 2'b00;

    always #5 CLK = ~CLK;

    irrigation_scheduler #(
        .ASP_TIME   (3),
        .GOT_TIME   (20),
        .PAUSE_TIME (2)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .tick      (tick),
        .req_asp   (req_asp),
        .req_got   (req_got),
        .tank_low  (tank_low),
        .clr_fault (clr_fault),
        .rega      (rega),
        .busy      (busy),
        .alarm     (alarm)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Cycle invariants: no 11 code, busy/alarm track state, no direct zone swap.
    always @(negedge CLK) begin
        if (mon_en && !reset) begin
            assert (rega !== 2'b11) else begin
                errors++;
                $error("FAIL inv_rega11: observed %b expected not 11", rega);
            end
            assert (busy === (dut.state != irrig_pkg::IDLE)) else begin
                errors++;
                $error("FAIL inv_busy: observed %b expected %b", busy, dut.state != irrig_pkg::IDLE);
            end
            assert (alarm === (dut.state == irrig_pkg::FAULT)) else begin
                errors++;
                $error("FAIL inv_alarm: observed %b expected %b", alarm, dut.state == irrig_pkg::FAULT);
            end
            assert (!((prev_rega == R_ASP && rega == R_GOT) || (prev_rega == R_GOT && rega == R_ASP))) else begin
                errors++;
                $error("FAIL inv_swap: observed %b->%b expected a 00 step between zones", prev_rega, rega);
            end
        end
        prev_rega <= rega;
    end

    initial begin
        reset = 1'b1; tick = 1'b0; req_asp = 1'b0; req_got = 1'b0;
        tank_low = 1'b0; clr_fault = 1'b0;
        cyc(2);
        chk("rst_rega",  rega,  R_NONE);
        chk("rst_busy",  {1'b0, busy},  2'b00);
        chk("rst_alarm", {1'b0, alarm}, 2'b00);
        reset = 1'b0;
        mon_en = 1'b1;
        cyc(1);
        chk("idle_busy", {1'b0, busy}, 2'b00);

        // Sprinkler run, 3 ticks spaced 4 cycles apart, then 2-tick pause.
        req_asp = 1'b1;
        cyc(1);
        chk("t1_start", rega, R_ASP);
        chk("t1_busy",  {1'b0, busy}, 2'b01);
        for (int k = 0; k < 3; k++) begin
            cyc(3);
            chk("t1_hold", rega, R_ASP);
            ticks(1);
        end
        chk("t1_pause_rega", rega, R_NONE);
        chk("t1_pause_busy", {1'b0, busy}, 2'b01);
        req_asp = 1'b0;
        cyc(3); ticks(1);
        chk("t1_pause_mid", {1'b0, busy}, 2'b01);
        cyc(3); ticks(1);
        chk("t1_idle_busy", {1'b0, busy}, 2'b00);
        chk("t1_idle_rega", rega, R_NONE);
        cyc(2);
        chk("t1_idle_stay", {1'b0, busy}, 2'b00);

        // Contention after reset: ASP, GOT, ASP with pauses between.
        reset = 1'b1; cyc(1); reset = 1'b0;
        req_asp = 1'b1; req_got = 1'b1;
        cyc(1);
        chk("t2_grant1", rega, R_ASP);
        ticks(3);
        chk("t2_pause1", rega, R_NONE);
        ticks(1);
        chk("t2_pause1_hold", {1'b0, busy}, 2'b01);
        ticks(1);
        chk("t2_idle1", {1'b0, busy}, 2'b00);
        cyc(1);
        chk("t2_grant2", rega, R_GOT);
        ticks(19);
        chk("t2_got_hold", rega, R_GOT);
        ticks(1);
        chk("t2_pause2", rega, R_NONE);
        ticks(2);
        chk("t2_idle2", {1'b0, busy}, 2'b00);
        cyc(1);
        chk("t2_grant3", rega, R_ASP);
        req_asp = 1'b0; req_got = 1'b0;
        cyc(1);
        chk("t2_stop", rega, R_NONE);
        ticks(2);
        chk("t2_idle3", {1'b0, busy}, 2'b00);

        // Tank low during drip run, tick in the same cycle.
        req_got = 1'b1;
        cyc(1);
        chk("t3_got", rega, R_GOT);
        ticks(2);
        chk("t3_got_hold", rega, R_GOT);
        tank_low = 1'b1; tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("t3_fault_rega",  rega, R_NONE);
        chk("t3_fault_alarm", {1'b0, alarm}, 2'b01);
        chk("t3_fault_busy",  {1'b0, busy},  2'b01);
        clr_fault = 1'b1;
        cyc(1);
        chk("t3_fault_stay", {1'b0, alarm}, 2'b01);
`ifdef IRRIG_FAULT_LATCH_EN
        tank_low = 1'b0; clr_fault = 1'b0;
        cyc(2);
        chk("t3_fault_sticky", {1'b0, alarm}, 2'b01);
        clr_fault = 1'b1;
`else
        tank_low = 1'b0; clr_fault = 1'b0;
`endif
        cyc(1);
        clr_fault = 1'b0;
        chk("t3_exit_alarm", {1'b0, alarm}, 2'b00);
        chk("t3_exit_busy",  {1'b0, busy},  2'b01);
        chk("t3_exit_rega",  rega, R_NONE);
        req_got = 1'b0;
        ticks(1);
        chk("t3_pause_mid", {1'b0, busy}, 2'b01);
        ticks(1);
        chk("t3_idle", {1'b0, busy}, 2'b00);

        // Drip dropped after 5 ticks: early stop, full pause.
        req_got = 1'b1;
        cyc(1);
        chk("t4_got", rega, R_GOT);
        ticks(5);
        chk("t4_got_hold", rega, R_GOT);
        req_got = 1'b0;
        cyc(1);
        chk("t4_stop_rega", rega, R_NONE);
        chk("t4_stop_busy", {1'b0, busy}, 2'b01);
        cyc(3);
        chk("t4_pause_notick", {1'b0, busy}, 2'b01);
        ticks(1);
        chk("t4_pause_mid", {1'b0, busy}, 2'b01);
        ticks(1);
        chk("t4_idle", {1'b0, busy}, 2'b00);

        // Reset during sprinkler run with tank low overrides everything.
        req_asp = 1'b1;
        cyc(1);
        chk("t5_asp", rega, R_ASP);
        ticks(1);
        tank_low = 1'b1; reset = 1'b1;
        cyc(1);
        chk("t5_rst_rega",  rega, R_NONE);
        chk("t5_rst_alarm", {1'b0, alarm}, 2'b00);
        chk("t5_rst_busy",  {1'b0, busy},  2'b00);
        reset = 1'b0; tank_low = 1'b0; req_got = 1'b1;
        cyc(1);
        chk("t5_grant", rega, R_ASP);
        req_asp = 1'b0; req_got = 1'b0;
        cyc(1);
        chk("t5_stop", rega, R_NONE);
        ticks(2);
        chk("t5_idle", {1'b0, busy}, 2'b00);

        // Tank low while idle.
        tank_low = 1'b1;
        cyc(1);
        chk("t6_fault_alarm", {1'b0, alarm}, 2'b01);
        chk("t6_fault_busy",  {1'b0, busy},  2'b01);
        tank_low = 1'b0;
`ifdef IRRIG_FAULT_LATCH_EN
        clr_fault = 1'b1;
`endif
        cyc(1);
        clr_fault = 1'b0;
        chk("t6_exit_alarm", {1'b0, alarm}, 2'b00);
        chk("t6_exit_busy",  {1'b0, busy},  2'b01);
        ticks(2);
        chk("t6_idle", {1'b0, busy}, 2'b00);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
